// File: rtl/mul4_sched.sv
// mul4_sched: two-requester 4x4 unsigned multiplier with round-robin arbitration.
// Each granted product is built from four 2x2 partial products, one per clock
// in MUL, followed by a single-cycle DONE that presents the result and the ack.
module mul4_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] p,
  output logic       p_id,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] p_q, p_d;
  logic       p_id_q, p_id_d;
  logic       id_q, id_d;
  logic       last_id_q, last_id_d;

  logic       gnt;
  logic [1:0] a_sl;
  logic [1:0] b_sl;
  logic [3:0] pp;
  logic [2:0] sh;
  logic [7:0] term;
  logic [7:0] sum;

  // Partial product for the current step: i=k[1] picks the A pair, j=k[0] the B pair.
  always_comb begin
    a_sl = k_q[1] ? a_q[3:2] : a_q[1:0];
    b_sl = k_q[0] ? b_q[3:2] : b_q[1:0];
    pp   = {2'b00, a_sl} * {2'b00, b_sl};
    sh   = {1'b0, k_q[1], 1'b0} + {1'b0, k_q[0], 1'b0};
    term = {4'b0000, pp} << sh;
    sum  = acc_q + term;
  end

  // Next-state logic: arbitration in IDLE, accumulation in MUL, one-cycle DONE.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    p_d       = p_q;
    p_id_d    = p_id_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    gnt       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Both pending: the one not served last wins; otherwise the lone requester.
          gnt       = (req0 && req1) ? ~last_id_q : req1;
          id_d      = gnt;
          last_id_d = gnt;
          a_d       = gnt ? a1 : a0;
          b_d       = gnt ? b1 : b0;
          acc_d     = '0;
          k_d       = '0;
          state_d   = MUL;
        end
      end
      MUL: begin
        acc_d = sum;
        k_d   = k_q + 2'd1;
        if (k_q == 2'd3) begin
          p_d     = sum;
          p_id_d  = id_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; last_id resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      p_q       <= '0;
      p_id_q    <= 1'b0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      p_q       <= p_d;
      p_id_q    <= p_id_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
    end
  end

  assign valid = (state_q == DONE);
  assign ack0  = valid & ~p_id_q;
  assign ack1  = valid & p_id_q;
  assign busy  = (state_q != IDLE);
  assign p     = p_q;
  assign p_id  = p_id_q;

endmodule

// File: tb/tb_mul4_sched.sv
// Testbench for mul4_sched: vector table plus directed multi-cycle sequences,
// with a scoreboard queue checked by a monitor whenever valid is seen.
module tb_mul4_sched;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       ack0, ack1, valid, busy, p_id;
  logic [7:0] p;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic       id;
    logic [7:0] p;
  } exp_t;

  exp_t sb[$];

  typedef struct packed {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp_p;
  } vec_t;

  vec_t vecs[8];

  mul4_sched dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .a0   (a0),
    .b0   (b0),
    .req1 (req1),
    .a1   (a1),
    .b1   (b1),
    .ack0 (ack0),
    .ack1 (ack1),
    .p    (p),
    .p_id (p_id),
    .valid(valid),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until valid is seen (at most 20 edges); n = edges consumed.
  task automatic wait_valid(output int n);
    n = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      n++;
      if (valid === 1'b1) break;
    end
    if (valid !== 1'b1) chk("wait_valid_timeout", {31'd0, valid}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst && valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: got p=%0d p_id=%0d with no result pending", p, p_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_p", {24'd0, p}, {24'd0, e.p});
        chk("sb_p_id", {31'd0, p_id}, {31'd0, e.id});
        chk("sb_ack0", {31'd0, ack0}, {31'd0, ~e.id});
        chk("sb_ack1", {31'd0, ack1}, {31'd0, e.id});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{id: 1'b0, a: 4'd0,  b: 4'd0,  exp_p: 8'd0};
    vecs[1] = '{id: 1'b1, a: 4'd15, b: 4'd15, exp_p: 8'd225};
    vecs[2] = '{id: 1'b0, a: 4'd1,  b: 4'd1,  exp_p: 8'd1};
    vecs[3] = '{id: 1'b1, a: 4'd10, b: 4'd12, exp_p: 8'd120};
    vecs[4] = '{id: 1'b0, a: 4'd7,  b: 4'd8,  exp_p: 8'd56};
    vecs[5] = '{id: 1'b1, a: 4'd15, b: 4'd1,  exp_p: 8'd15};
    vecs[6] = '{id: 1'b0, a: 4'd0,  b: 4'd9,  exp_p: 8'd0};
    vecs[7] = '{id: 1'b1, a: 4'd12, b: 4'd13, exp_p: 8'd156};

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // Reset state visible before any clock edge.
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_p", {24'd0, p}, 32'd0);
    chk("rst_p_id", {31'd0, p_id}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single request with cycle-exact timing.
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
    sb.push_back('{id: 1'b0, p: 8'h0F});
    tick();
    chk("single_busy_E0", {31'd0, busy}, 32'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("single_no_valid_early", {31'd0, valid}, 32'd0);
    end
    tick();
    chk("single_valid_E4", {31'd0, valid}, 32'd1);
    chk("single_ack0_E4", {31'd0, ack0}, 32'd1);
    chk("single_ack1_E4", {31'd0, ack1}, 32'd0);
    chk("single_p", {24'd0, p}, 32'h0F);
    chk("single_p_id", {31'd0, p_id}, 32'd0);
    req0 = 1'b0;
    tick();
    chk("single_idle_E5", {31'd0, busy}, 32'd0);
    chk("single_valid_E5", {31'd0, valid}, 32'd0);
    chk("single_p_hold", {24'd0, p}, 32'h0F);

    // Table of single-requester products.
    for (int unsigned v = 0; v < 8; v++) begin
      if (vecs[v].id) begin
        req1 = 1'b1; a1 = vecs[v].a; b1 = vecs[v].b;
      end else begin
        req0 = 1'b1; a0 = vecs[v].a; b0 = vecs[v].b;
      end
      sb.push_back('{id: vecs[v].id, p: vecs[v].exp_p});
      wait_valid(n);
      chk("tbl_latency", n, 32'd5);
      chk("tbl_p", {24'd0, p}, {24'd0, vecs[v].exp_p});
      chk("tbl_p_id", {31'd0, p_id}, {31'd0, vecs[v].id});
      req0 = 1'b0; req1 = 1'b0;
      tick();
      chk("tbl_idle", {31'd0, busy}, 32'd0);
    end

    // Simultaneous first requests after reset: requester 0 first, then 1 six cycles later.
    do_reset();
    req0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
    req1 = 1'b1; a1 = 4'd2;  b1 = 4'd7;
    sb.push_back('{id: 1'b0, p: 8'd225});
    sb.push_back('{id: 1'b1, p: 8'd14});
    wait_valid(n);
    chk("simul_first_lat", n, 32'd5);
    chk("simul_first_p", {24'd0, p}, 32'd225);
    chk("simul_first_id", {31'd0, p_id}, 32'd0);
    req0 = 1'b0;
    wait_valid(n);
    chk("simul_second_gap", n, 32'd6);
    chk("simul_second_p", {24'd0, p}, 32'd14);
    chk("simul_second_id", {31'd0, p_id}, 32'd1);
    req1 = 1'b0;
    tick();

    // Fairness: req0 held throughout, req1 raised after the first grant.
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd11;
    a1 = 4'd13; b1 = 4'd6;
    for (int unsigned i = 0; i < 4; i++)
      sb.push_back('{id: i[0], p: i[0] ? 8'd78 : 8'd55});
    tick();
    req1 = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      wait_valid(n);
      chk("fair_gap", n, (i == 0) ? 32'd4 : 32'd6);
      chk("fair_id", {31'd0, p_id}, {31'd0, i[0]});
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Operand stability: operands change and request drops after grant.
    req0 = 1'b1; a0 = 4'd9; b0 = 4'd13;
    sb.push_back('{id: 1'b0, p: 8'd117});
    tick();
    a0 = 4'd2; b0 = 4'd3; req0 = 1'b0;
    wait_valid(n);
    chk("stable_p", {24'd0, p}, 32'd117);
    chk("stable_id", {31'd0, p_id}, 32'd0);
    tick();

    // Reset during MUL with k=2; req1 held through reset.
    req1 = 1'b1; a1 = 4'd6; b1 = 4'd9;
    tick();
    tick();
    tick();
    chk("midrst_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    sb.delete();
    #2;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_p", {24'd0, p}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    tick();
    chk("midrst_busy_held", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    sb.push_back('{id: 1'b1, p: 8'd54});
    wait_valid(n);
    chk("midrst_lat", n, 32'd5);
    chk("midrst_p_after", {24'd0, p}, 32'd54);
    chk("midrst_id_after", {31'd0, p_id}, 32'd1);
    chk("midrst_ack1", {31'd0, ack1}, 32'd1);
    req1 = 1'b0;
    tick();

    // Asynchronous reset pulse during DONE, between clock edges.
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd3;
    sb.push_back('{id: 1'b0, p: 8'd9});
    wait_valid(n);
    chk("donerst_p_before", {24'd0, p}, 32'd9);
    rst = 1'b1;
    req0 = 1'b0;
    sb.delete();
    #2;
    chk("donerst_valid", {31'd0, valid}, 32'd0);
    chk("donerst_ack0", {31'd0, ack0}, 32'd0);
    chk("donerst_busy", {31'd0, busy}, 32'd0);
    chk("donerst_p", {24'd0, p}, 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("donerst_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
